// File: rtl/lime_mc_sequencer.sv
// Multi-cycle control sequencer for the Lime core: handshakes with variable-latency
// memory, detects memory timeouts, supports HALT and counts retired instructions.
module lime_mc_sequencer #(
  parameter int              OPW         = 7,
  parameter int              ALUOPW      = 4,
  parameter int              CNTW        = 16,
  parameter int              TOW         = 8,
  parameter int              MEM_TIMEOUT = 64,
  parameter logic [OPW-1:0]  OP_LW       = 7'h10,
  parameter logic [OPW-1:0]  OP_SW       = 7'h11,
  parameter logic [OPW-1:0]  OP_BEQ      = 7'h20,
  parameter logic [OPW-1:0]  OP_BLT      = 7'h21,
  parameter logic [OPW-1:0]  OP_JMP      = 7'h22,
  parameter logic [OPW-1:0]  OP_HALT     = 7'h7F,
  parameter logic [ALUOPW-1:0] ADD_OP    = 4'h0,
  parameter logic [ALUOPW-1:0] SUB_OP    = 4'h1,
  parameter int              IMM_BIT     = 6
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ior_d,
  output logic              mem_req,
  output logic              mem_we,
  output logic              ir_write,
  output logic              mem2reg,
  output logic              reg_write,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic              pc_src,
  output logic              branch,
  output logic [1:0]        branch_type,
  output logic [3:0]        state,
  output logic              halted,
  output logic              fault,
  output logic [CNTW-1:0]   retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_WB_ALU   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_WB_MEM   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_HALT     = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  localparam bit            TO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [TOW-1:0] TO_LIMIT = TO_EN ? TOW'(MEM_TIMEOUT - 1) : {TOW{1'b0}};

  state_t          state_r;
  state_t          next_state_s;
  logic [TOW-1:0]  wait_r;
  logic [TOW-1:0]  wait_next_s;
  logic [CNTW-1:0] retired_r;
  logic            retire_s;
  logic            mem_state_s;
  logic            timeout_s;

  assign timeout_s = TO_EN && (wait_r == TO_LIMIT);
  assign state     = state_r;
  assign retired   = retired_r;

  // Next-state, retirement and control strobes, all decoded from the current state.
  always_comb begin
    next_state_s = state_r;
    retire_s     = 1'b0;
    mem_state_s  = 1'b0;
    pc_write     = 1'b0;
    ior_d        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_write     = 1'b0;
    mem2reg      = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 2'd0;
    alu_src_b    = 2'd0;
    alu_op       = ADD_OP;
    pc_src       = 1'b0;
    branch       = 1'b0;
    branch_type  = 2'd0;
    halted       = 1'b0;
    fault        = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_state_s = 1'b1;
        mem_req     = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          alu_src_b    = 2'd1;
          next_state_s = S_DECODE;
        end else if (timeout_s) begin
          next_state_s = S_FAULT;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd2;
        if (opcode == OP_HALT) begin
          next_state_s = S_HALT;
          retire_s     = 1'b1;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          next_state_s = S_MEM_ADDR;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BLT)) begin
          next_state_s = S_BRANCH;
        end else if (opcode == OP_JMP) begin
          next_state_s = S_JUMP;
        end else begin
          next_state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a    = 2'd1;
        alu_src_b    = opcode[IMM_BIT] ? 2'd2 : 2'd0;
        alu_op       = opcode[ALUOPW-1:0];
        next_state_s = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write    = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a    = 2'd1;
        alu_src_b    = 2'd2;
        next_state_s = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_state_s = 1'b1;
        mem_req     = 1'b1;
        ior_d       = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          next_state_s = S_WB_MEM;
        end else if (timeout_s) begin
          next_state_s = S_FAULT;
        end else begin
          next_state_s = S_MEM_RD;
        end
      end
      S_WB_MEM: begin
        reg_write    = 1'b1;
        mem2reg      = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_WR: begin
        mem_state_s = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        ior_d       = 1'b1;
        if (mem_ready) begin
          retire_s     = 1'b1;
          next_state_s = S_FETCH;
        end else if (timeout_s) begin
          next_state_s = S_FAULT;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_BRANCH: begin
        alu_src_a    = 2'd1;
        alu_op       = SUB_OP;
        branch       = 1'b1;
        pc_src       = 1'b1;
        branch_type  = (opcode == OP_BLT) ? 2'd1 : 2'd0;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        pc_write     = 1'b1;
        pc_src       = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_HALT: begin
        halted       = 1'b1;
        next_state_s = S_HALT;
      end
      S_FAULT: begin
        fault        = 1'b1;
        next_state_s = S_FAULT;
      end
      default: begin
        next_state_s = S_FAULT;
      end
    endcase
  end

  // The wait counter is held at zero outside memory states, so entry always starts from 0.
  always_comb begin
    if (mem_state_s && !mem_ready) begin
      wait_next_s = wait_r + TOW'(1);
    end else begin
      wait_next_s = {TOW{1'b0}};
    end
  end

  // State, wait counter and retired-instruction counter registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r   <= S_FETCH;
      wait_r    <= {TOW{1'b0}};
      retired_r <= {CNTW{1'b0}};
    end else begin
      state_r <= next_state_s;
      wait_r  <= wait_next_s;
      if (retire_s) begin
        retired_r <= retired_r + CNTW'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

endmodule
